// File: rtl/game_pkg.sv
// Shared geometry, brick-map layout and FSM encoding for the brick-breaker
// state sequencer.
package game_pkg;

  localparam int H       = 640;
  localparam int V       = 480;
  localparam int BALL_W  = 16;
  localparam int BALL_H  = 10;
  localparam int BOARD_W = 96;
  localparam int BOARD_Y = 467;

  localparam int CELL_W      = 32;
  localparam int CELL_H      = 20;
  localparam int BRICK_COLS  = 20;
  localparam int BRICK_ROWS  = 24;
  localparam int BRICK_BITS  = 3;
  localparam int BRICK_MAP_W = BRICK_COLS * BRICK_ROWS * BRICK_BITS;

  typedef enum logic [2:0] {
    ST_SERVE = 3'd0,
    ST_PLAY  = 3'd1,
    ST_OVER  = 3'd2,
    ST_WIN   = 3'd3
  } state_t;

  // Rows 0..rows-1 start with one hit point per cell; the rest are empty.
  function automatic logic [BRICK_MAP_W-1:0] init_bricks(input int rows);
    logic [BRICK_MAP_W-1:0] m;
    m = '0;
    for (int r = 0; r < BRICK_ROWS; r++) begin
      for (int c = 0; c < BRICK_COLS; c++) begin
        if (r < rows) begin
          m[BRICK_BITS*c + BRICK_BITS*BRICK_COLS*r +: BRICK_BITS] = 3'd1;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/game_state_seq_board_mover.sv
// Paddle position register: steps left/right once per frame tick, clamps to
// the screen, holds when both or neither button is pressed.
module board_mover
  import game_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       en_i,
  input  logic       load_i,
  output logic [9:0] board_x_o,
  output logic [9:0] board_x_next_o
);

  localparam logic [10:0] X_MAX  = 11'(H - BOARD_W);
  localparam logic [9:0]  X_INIT = 10'((H - BOARD_W) / 2);

  logic [9:0]  board_x_q;
  logic [9:0]  board_x_d;
  logic [10:0] sum;

  always_comb begin
    board_x_d = board_x_q;
    sum       = {1'b0, board_x_q};
    if (tick_i) begin
      if (load_i) begin
        board_x_d = X_INIT;
      end else if (en_i && left_i && !right_i) begin
        // Underflow wraps into bit 10, which doubles as the below-zero flag.
        sum       = {1'b0, board_x_q} - 11'(STEP);
        board_x_d = sum[10] ? 10'd0 : sum[9:0];
      end else if (en_i && right_i && !left_i) begin
        sum       = {1'b0, board_x_q} + 11'(STEP);
        board_x_d = (sum > X_MAX) ? X_MAX[9:0] : sum[9:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_x_q <= X_INIT;
    end else begin
      board_x_q <= board_x_d;
    end
  end

  assign board_x_o      = board_x_q;
  assign board_x_next_o = board_x_d;

endmodule

// File: rtl/game_state_seq.sv
// Frame sequencer for the brick-breaker game: holds ball/brick/paddle/score
// state and runs serve/play/lost/win flow. Optional macro: SPEEDUP_EN.
module game_state_seq
  import game_pkg::*;
#(
  parameter int BOARD_STEP = 8,
  parameter int VX_INIT    = 4,
  parameter int VY_INIT    = 4,
  parameter int VY_MAX     = 10,
  parameter int INIT_ROWS  = 6,
  parameter int LIVES_INIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_launch,
  input  logic [BRICK_MAP_W-1:0] next_bricks,
  input  logic [9:0]             next_ball_x,
  input  logic [9:0]             next_ball_y,
  input  logic [9:0]             next_ball_vx,
  input  logic [9:0]             next_ball_vy,
  input  logic [1:0]             next_ball_dir,
  output logic [BRICK_MAP_W-1:0] bricks,
  output logic [9:0]             ball_x,
  output logic [9:0]             ball_y,
  output logic [9:0]             ball_vx,
  output logic [9:0]             ball_vy,
  output logic [1:0]             ball_dir,
  output logic [9:0]             board_x,
  output logic [1:0]             lives,
  output logic [15:0]            score,
  output logic [2:0]             game_state
);

  localparam logic [9:0]             BOARD_X0 = 10'((H - BOARD_W) / 2);
  localparam logic [9:0]             BALL_OFS = 10'd40;
  localparam logic [9:0]             SERVE_Y  = 10'(BOARD_Y - BALL_H);
  localparam logic [1:0]             LIVES0   = 2'(LIVES_INIT);
  localparam logic [BRICK_MAP_W-1:0] BRICKS0  = init_bricks(INIT_ROWS);

  // A larger ceiling would let the ball jump over the paddle row in one frame.
  if (VY_MAX > 10) begin : g_vy_max_check
    $error("VY_MAX must not exceed 10");
  end

  state_t                 state_q;
  logic [1:0]             lives_q;
  logic [15:0]            score_q;
  logic [9:0]             ball_x_q, ball_y_q, ball_vx_q, ball_vy_q;
  logic [1:0]             ball_dir_q;
  logic [BRICK_MAP_W-1:0] bricks_q;
  logic                   launch_pend_q, launch_prev_q;

  logic        launch_edge, launch_now, frozen, reinit;
  logic        miss, brick_hit;
  logic [10:0] miss_sum;
  logic [15:0] score_d;
  logic [9:0]  vy_commit_d;
  logic [9:0]  board_x_cur, board_x_d;

  assign launch_edge = btn_launch & ~launch_prev_q;
  assign launch_now  = launch_pend_q | launch_edge;
  assign frozen      = (state_q == ST_OVER) || (state_q == ST_WIN);
  assign reinit      = tick & frozen & launch_now;

  assign miss_sum  = {1'b0, ball_y_q} + 11'(BALL_H) + {1'b0, ball_vy_q};
  assign miss      = ball_dir_q[0] && (miss_sum > 11'(V));
  assign brick_hit = (next_bricks != bricks_q);
  assign score_d   = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

`ifdef SPEEDUP_EN
  logic [2:0]  hits_q;
  logic [10:0] vy_inc;

  assign vy_inc = {1'b0, next_ball_vy} + 11'd1;

  // Every eighth scoring frame nudges the fall speed up, capped at VY_MAX.
  always_comb begin
    vy_commit_d = next_ball_vy;
    if (brick_hit && (hits_q == 3'd7)) begin
      vy_commit_d = (vy_inc > 11'(VY_MAX)) ? 10'(VY_MAX) : vy_inc[9:0];
    end
  end
`else
  assign vy_commit_d = next_ball_vy;
`endif

  board_mover #(.STEP(BOARD_STEP)) u_board (
    .clk           (clk),
    .rst           (rst),
    .tick_i        (tick),
    .left_i        (btn_left),
    .right_i       (btn_right),
    .en_i          (~frozen),
    .load_i        (reinit),
    .board_x_o     (board_x_cur),
    .board_x_next_o(board_x_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SERVE;
      lives_q       <= LIVES0;
      score_q       <= '0;
      ball_x_q      <= BOARD_X0 + BALL_OFS;
      ball_y_q      <= SERVE_Y;
      ball_vx_q     <= '0;
      ball_vy_q     <= '0;
      ball_dir_q    <= 2'b10;
      bricks_q      <= BRICKS0;
      launch_pend_q <= 1'b0;
      launch_prev_q <= 1'b0;
`ifdef SPEEDUP_EN
      hits_q        <= '0;
`endif
    end else begin
      launch_prev_q <= btn_launch;
      if (tick) begin
        launch_pend_q <= 1'b0;
      end else if (launch_edge) begin
        launch_pend_q <= 1'b1;
      end

      if (tick) begin
        case (state_q)
          ST_SERVE: begin
            ball_x_q <= board_x_d + BALL_OFS;
            ball_y_q <= SERVE_Y;
`ifdef SPEEDUP_EN
            hits_q   <= '0;
`endif
            if (launch_now) begin
              state_q    <= ST_PLAY;
              ball_dir_q <= 2'b10;
              ball_vx_q  <= 10'(VX_INIT);
              ball_vy_q  <= 10'(VY_INIT);
            end
          end

          ST_PLAY: begin
            if (miss) begin
              lives_q <= lives_q - 2'd1;
              state_q <= (lives_q == 2'd1) ? ST_OVER : ST_SERVE;
            end else begin
              bricks_q   <= next_bricks;
              ball_x_q   <= next_ball_x;
              ball_y_q   <= next_ball_y;
              ball_vx_q  <= next_ball_vx;
              ball_vy_q  <= vy_commit_d;
              ball_dir_q <= next_ball_dir;
              if (brick_hit) begin
                score_q <= score_d;
`ifdef SPEEDUP_EN
                hits_q  <= hits_q + 3'd1;
`endif
              end
              if (next_bricks == '0) begin
                state_q <= ST_WIN;
              end
            end
          end

          ST_OVER, ST_WIN: begin
            if (launch_now) begin
              state_q    <= ST_SERVE;
              lives_q    <= LIVES0;
              score_q    <= '0;
              ball_x_q   <= BOARD_X0 + BALL_OFS;
              ball_y_q   <= SERVE_Y;
              ball_vx_q  <= '0;
              ball_vy_q  <= '0;
              ball_dir_q <= 2'b10;
              bricks_q   <= BRICKS0;
`ifdef SPEEDUP_EN
              hits_q     <= '0;
`endif
            end
          end

          default: state_q <= ST_SERVE;
        endcase
      end
    end
  end

  assign bricks     = bricks_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign ball_vx    = ball_vx_q;
  assign ball_vy    = ball_vy_q;
  assign ball_dir   = ball_dir_q;
  assign board_x    = board_x_cur;
  assign lives      = lives_q;
  assign score      = score_q;
  assign game_state = state_q;

endmodule
